// File: rtl/shift4_deser.sv
// -----------------------------------------------------------------------------
// shift4_deser
// Serial-in / parallel-out deserializer. This is the receive side of the Shift4
// right-shift transmitter. It collects SIZE bits LSB-first, qualified by ena and
// framed by start. Each completed word is presented on a valid/ready output
// register, with overrun and frame-error pulses.
//
// Ports
//   clk        in   1     rising-edge clock
//   areset_n   in   1     asynchronous active-low reset
//   start      in   1     frame start: arms receiver, clears bit count
//   ena        in   1     serial bit valid this cycle
//   sdata      in   1     serial data bit, word LSB first
//   out_ready  in   1     consumer accepts out_data this cycle
//   out_valid  out  1     out_data holds an unconsumed word
//   out_data   out  SIZE  last completed word
//   busy       out  1     receiver is mid-frame (SHIFT state)
//   overrun    out  1     one-cycle pulse: completed word dropped
//   frame_err  out  1     one-cycle pulse: start seen mid-frame
// -----------------------------------------------------------------------------
module shift4_deser #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic            start,
    input  logic            ena,
    input  logic            sdata,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            busy,
    output logic            overrun,
    output logic            frame_err
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e          state_q, state_d;
    // Only SIZE-1 received bits need storing: the final bit arrives on
    // sdata in the same cycle as the completion edge.
    logic [SIZE-2:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            vld_q, vld_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;

    logic [SIZE-1:0] word;
    logic            done;

    // The incoming bit is placed at the MSB. After SIZE bits have been
    // received, the first bit has reached position 0.
    assign word = {sdata, sr_q};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    if (ena) begin
                        sr_d  = word[SIZE-1:1];
                        cnt_d = CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (ena && cnt_q == LAST) begin
                    // A completion takes priority over start. When start is also
                    // asserted, the next frame is re-armed with an empty count,
                    // because this ena was spent on the last bit.
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = start ? SHIFT : IDLE;
                end else if (start) begin
                    ferr_d = 1'b1;
                    cnt_d  = '0;
                    if (ena) begin
                        sr_d  = word[SIZE-1:1];
                        cnt_d = CW'(1);
                    end
                end else if (ena) begin
                    sr_d  = word[SIZE-1:1];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register. A new word is loaded only if the slot is empty or is
    // being drained on this same edge. Otherwise the new word is dropped.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        ovr_d  = 1'b0;
        if (done) begin
            if (!vld_q || out_ready) begin
                data_d = word;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule
